// File: rtl/host_spi_bridge.sv
// host_spi_bridge: oversampled SPI-slave to CPU-bus bridge sharing a read-first word buffer; define HOST_SPI_SEQ_EN to carry a 4-bit sequence counter in the status header
module host_spi_bridge #(
  parameter int SPI_W     = 16,
  parameter int BUF_DEPTH = 2048,
  parameter int NCH       = 5,
  parameter int NSYNC     = 2
) (
  input  logic               hb_clk,
  input  logic               hb_rst_n,
  input  logic               spi_sclk,
  input  logic               spi_cs_n,
  input  logic               spi_mosi,
  output logic               spi_miso,
  input  logic [NCH-1:0]     ch_rd,
  input  logic [NCH*16-1:0]  ch_dout,
  input  logic               host_wr,
  input  logic [15:0]        tos,
  input  logic               host_rd,
  input  logic               host_rst,
  input  logic               host_rdy,
  output logic [15:0]        host_dout,
  output logic               host_srq,
  input  logic               hb_ovfl,
  output logic               hb_orst
);
  localparam int AW = BUF_DEPTH > 1 ? $clog2(BUF_DEPTH) : 1;
  localparam int KW = AW + 1;
  localparam logic [KW-1:0] K_MAX = KW'(BUF_DEPTH);
  typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;
  state_t st, st_n;
  logic [15:0] mem [BUF_DEPTH];
  logic [NSYNC-1:0] sclk_s, cs_s, mosi_s;
  logic sclk_d, cs_d, sclk_rise, sclk_fall, cs_fall, cs_rise, mosi_b;
  logic rdy, ack, ovfl, ld, spi_we, wr, txn_end;
  logic [5:0] bc;
  logic [KW-1:0] k;
  logic [31:0] tx;
  logic [14:0] rx;
  logic [15:0] spi_wd, ld_word, cpu_wd, pf;
  logic [AW-1:0] spi_wa, addr, pos, pos_n, pf_a;
  logic [3:0] seq;

  assign sclk_rise = sclk_s[NSYNC-1] & ~sclk_d;
  assign sclk_fall = ~sclk_s[NSYNC-1] & sclk_d;
  assign cs_fall   = ~cs_s[NSYNC-1] & cs_d;
  assign cs_rise   = cs_s[NSYNC-1] & ~cs_d;
  assign mosi_b    = mosi_s[NSYNC-1];
  assign txn_end   = cs_rise && st != IDLE && ack;
  assign ld        = sclk_fall && st == DATA && bc == 6'd0;
  assign ld_word   = (ack && k < K_MAX) ? mem[k[AW-1:0]] : 16'h0;
  assign spi_we    = hb_rst_n && sclk_rise && st == DATA && bc == 6'd15 && ack && k < K_MAX;
  assign spi_wd    = {rx, mosi_b};
  assign spi_wa    = k[AW-1:0];
  assign wr        = host_wr | (|ch_rd);
  assign addr      = host_rst ? '0 : pos + AW'(host_rd);
  assign pos_n     = addr + AW'(wr);
  assign pf_a      = hb_rst_n ? pos_n : '0;
  assign host_dout = host_rd ? pf : 16'h0;

  // Transaction phase register
  always_ff @(posedge hb_clk) st <= hb_rst_n ? st_n : IDLE;

  // Next phase: cs_n fall opens the header, SPI_W rises move to data, cs_n rise closes
  always_comb begin
    st_n = st;
    if (st == IDLE) st_n = cs_fall ? HDR : IDLE;
    else if (cs_rise) st_n = IDLE;
    else if (st == HDR && sclk_rise && bc == 6'(SPI_W-1)) st_n = DATA;
  end

  // CPU write data: lowest-indexed asserted channel, else top-of-stack
  always_comb begin
    cpu_wd = tos;
    for (int i = NCH-1; i >= 0; i--) if (ch_rd[i]) cpu_wd = ch_dout[16*i +: 16];
  end

  // SPI synchronisers, shifters, handshake flags and CPU pointer
  always_ff @(posedge hb_clk) begin
    if (!hb_rst_n) begin
      sclk_s <= '0; cs_s <= '0; mosi_s <= '0; sclk_d <= 1'b0; cs_d <= 1'b0;
      rdy <= 1'b0; ack <= 1'b0; ovfl <= 1'b0; bc <= '0; k <= '0; tx <= '0; rx <= '0;
      spi_miso <= 1'b1; host_srq <= 1'b0; hb_orst <= 1'b0; pos <= '0;
    end else begin
      sclk_s <= NSYNC'({sclk_s, spi_sclk});
      cs_s <= NSYNC'({cs_s, spi_cs_n});
      mosi_s <= NSYNC'({mosi_s, spi_mosi});
      sclk_d <= sclk_s[NSYNC-1];
      cs_d <= cs_s[NSYNC-1];
      rdy <= ~host_srq & (rdy | host_rdy);
      host_srq <= txn_end;
      hb_orst <= ld && k == '0 && ovfl;
      spi_miso <= st == IDLE || tx[31];
      pos <= pos_n;
      if (st == IDLE && cs_fall) begin
        ack <= rdy;
        ovfl <= hb_ovfl;
        k <= '0;
        bc <= '0;
        tx <= {~rdy, hb_ovfl, seq, 26'h0};
      end else if (ld) tx <= {ld_word, 16'h0};
      else if (sclk_fall && st != IDLE) tx <= {tx[30:0], 1'b0};
      if (sclk_rise && st == HDR) bc <= bc == 6'(SPI_W-1) ? '0 : bc + 6'd1;
      if (sclk_rise && st == DATA) begin
        rx <= spi_wd[14:0];
        bc <= bc == 6'd15 ? '0 : bc + 6'd1;
        if (bc == 6'd15 && k < K_MAX) k <= k + KW'(1);
      end
    end
  end

`ifdef HOST_SPI_SEQ_EN
  // Sequence counter advances at the end of every acked transaction
  always_ff @(posedge hb_clk) seq <= !hb_rst_n ? 4'd0 : txn_end ? seq + 4'd1 : seq;
`else
  assign seq = 4'd0;
`endif

  // Buffer writes (SPI last so it wins an address collision) and CPU prefetch
  always_ff @(posedge hb_clk) begin
    if (hb_rst_n && wr) mem[addr] <= cpu_wd;
    if (spi_we) mem[spi_wa] <= spi_wd;
    pf <= (spi_we && spi_wa == pf_a) ? spi_wd : mem[pf_a];
  end
endmodule

// File: tb/tb_host_spi_bridge.sv
// tb_host_spi_bridge: directed bench for host_spi_bridge (SPI_W=16, BUF_DEPTH=4, NCH=5, NSYNC=2)
module tb_host_spi_bridge;
  localparam int NCH = 5;
`ifdef HOST_SPI_SEQ_EN
  localparam bit SEQ = 1'b1;
`else
  localparam bit SEQ = 1'b0;
`endif
  logic hb_clk = 1'b0, hb_rst_n = 1'b0;
  logic spi_sclk = 1'b0, spi_cs_n = 1'b1, spi_mosi = 1'b0, spi_miso;
  logic [NCH-1:0] ch_rd = '0;
  logic [NCH*16-1:0] ch_dout = {16'hC004, 16'hC003, 16'hC002, 16'hC001, 16'hC000};
  logic host_wr = 1'b0, host_rd = 1'b0, host_rst = 1'b0, host_rdy = 1'b0, hb_ovfl = 1'b0;
  logic [15:0] tos = '0, host_dout;
  logic host_srq, hb_orst;
  int checks = 0, failures = 0;
  int srq_cnt = 0, orst_cnt = 0, orst_bit = -1, bit_idx = 0, s0, o0;
  logic [15:0] mo_w [8];
  logic [15:0] mi_w [8];

  typedef struct {
    logic wr, rd, rst;
    logic [NCH-1:0] ch;
    logic [15:0] tos, dout;
  } vec_t;
  vec_t tv [16];

  always #5 hb_clk = ~hb_clk;

  host_spi_bridge #(.SPI_W(16), .BUF_DEPTH(4), .NCH(NCH), .NSYNC(2)) dut (
    .hb_clk(hb_clk), .hb_rst_n(hb_rst_n),
    .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
    .ch_rd(ch_rd), .ch_dout(ch_dout),
    .host_wr(host_wr), .tos(tos), .host_rd(host_rd), .host_rst(host_rst), .host_rdy(host_rdy),
    .host_dout(host_dout), .host_srq(host_srq), .hb_ovfl(hb_ovfl), .hb_orst(hb_orst)
  );

  always @(negedge hb_clk) begin
    if (host_srq) srq_cnt++;
    if (hb_orst) begin
      orst_cnt++;
      orst_bit = bit_idx;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  function automatic logic [15:0] hdr_exp(input bit busy, input bit ov, input int sq);
    return {busy, ov, SEQ ? 4'(sq) : 4'd0, 10'd0};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge hb_clk);
    #1;
  endtask

  task automatic push(input logic [15:0] d);
    host_wr = 1'b1; tos = d; tick(); host_wr = 1'b0;
  endtask

  task automatic cpu_rst();
    host_rst = 1'b1; tick(); host_rst = 1'b0;
  endtask

  task automatic arm();
    host_rdy = 1'b1; tick(); host_rdy = 1'b0;
  endtask

  task automatic rd_chk(input string n, input logic [15:0] e);
    host_rd = 1'b1;
    @(negedge hb_clk);
    check(n, host_dout, e);
    tick();
    host_rd = 1'b0;
  endtask

  // Mode-0 master: header word plus nw data words; optional reset pulse at bit rst_bit
  task automatic spi_txn(input int nw, input int rst_bit);
    spi_cs_n = 1'b0;
    #100;
    for (int b = 0; b < 16*(nw+1); b++) begin
      bit_idx = b;
      if (b == rst_bit) begin
        hb_rst_n = 1'b0; #30; hb_rst_n = 1'b1;
      end
      spi_mosi = mo_w[b/16][15 - b%16];
      #60;
      mi_w[b/16][15 - b%16] = spi_miso;
      spi_sclk = 1'b1;
      #60;
      spi_sclk = 1'b0;
    end
    #60;
    spi_cs_n = 1'b1;
    #100;
  endtask

  initial begin
    tv[0]  = '{1'b0, 1'b0, 1'b1, 5'b00000, 16'h0000, 16'h0000};
    tv[1]  = '{1'b1, 1'b0, 1'b0, 5'b00000, 16'h1111, 16'h0000};
    tv[2]  = '{1'b1, 1'b0, 1'b0, 5'b00000, 16'h2222, 16'h0000};
    tv[3]  = '{1'b0, 1'b0, 1'b0, 5'b10110, 16'h9999, 16'h0000};
    tv[4]  = '{1'b1, 1'b0, 1'b0, 5'b00001, 16'h3333, 16'h0000};
    tv[5]  = '{1'b0, 1'b1, 1'b0, 5'b00000, 16'h0000, 16'h1111};
    tv[6]  = '{1'b0, 1'b1, 1'b0, 5'b00000, 16'h0000, 16'h2222};
    tv[7]  = '{1'b0, 1'b1, 1'b0, 5'b00000, 16'h0000, 16'hC001};
    tv[8]  = '{1'b0, 1'b1, 1'b0, 5'b00000, 16'h0000, 16'hC000};
    tv[9]  = '{1'b0, 1'b0, 1'b1, 5'b00000, 16'h0000, 16'h0000};
    tv[10] = '{1'b0, 1'b1, 1'b0, 5'b00000, 16'h0000, 16'h1111};
    tv[11] = '{1'b1, 1'b1, 1'b0, 5'b00000, 16'h4444, 16'h2222};
    tv[12] = '{1'b0, 1'b1, 1'b1, 5'b00000, 16'h0000, 16'hC000};
    tv[13] = '{1'b0, 1'b1, 1'b0, 5'b00000, 16'h0000, 16'h1111};
    tv[14] = '{1'b0, 1'b1, 1'b0, 5'b00000, 16'h0000, 16'h2222};
    tv[15] = '{1'b0, 1'b1, 1'b0, 5'b00000, 16'h0000, 16'h4444};

    repeat (3) tick();
    check("rst_miso", spi_miso, 1);
    check("rst_srq", host_srq, 0);
    check("rst_orst", hb_orst, 0);
    check("rst_dout", host_dout, 0);
    hb_rst_n = 1'b1;
    repeat (4) tick();

    foreach (tv[i]) begin
      host_wr = tv[i].wr; host_rd = tv[i].rd; host_rst = tv[i].rst; ch_rd = tv[i].ch; tos = tv[i].tos;
      @(negedge hb_clk);
      check($sformatf("cpu_vec%0d", i), host_dout, tv[i].dout);
      tick();
    end
    host_wr = 1'b0; host_rd = 1'b0; host_rst = 1'b0; ch_rd = '0;

    // Idle poll: unarmed, busy header, zero data, no write, no srq
    s0 = srq_cnt;
    mo_w[0] = 16'hFFFF; mo_w[1] = 16'h1357; mo_w[2] = 16'h2468;
    spi_txn(2, -1);
    check("idle_hdr", mi_w[0], hdr_exp(1, 0, 0));
    check("idle_d0", mi_w[1], 16'h0000);
    check("idle_d1", mi_w[2], 16'h0000);
    check("idle_srq", srq_cnt - s0, 0);
    check("idle_miso_hi", spi_miso, 1);
    tick(); cpu_rst();
    rd_chk("idle_mem0", 16'h1111);
    rd_chk("idle_mem1", 16'h2222);

    // Armed exchange
    cpu_rst(); push(16'h1234); push(16'hABCD); arm();
    s0 = srq_cnt;
    mo_w[0] = 16'hFFFF; mo_w[1] = 16'h5555; mo_w[2] = 16'hAAAA;
    spi_txn(2, -1);
    check("arm_hdr", mi_w[0], hdr_exp(0, 0, 0));
    check("arm_d0", mi_w[1], 16'h1234);
    check("arm_d1", mi_w[2], 16'hABCD);
    check("arm_srq", srq_cnt - s0, 1);
    tick(); cpu_rst();
    rd_chk("arm_rd0", 16'h5555);
    rd_chk("arm_rd1", 16'hAAAA);

    // Overflow flagged (srq cleared rdy, so busy), then not flagged
    s0 = srq_cnt; o0 = orst_cnt; hb_ovfl = 1'b1;
    mo_w[0] = 16'h0000; mo_w[1] = 16'h0F0F;
    spi_txn(1, -1);
    hb_ovfl = 1'b0;
    check("ovf_hdr", mi_w[0], hdr_exp(1, 1, 1));
    check("ovf_d0", mi_w[1], 16'h0000);
    check("ovf_orst_cnt", orst_cnt - o0, 1);
    check("ovf_orst_bit", orst_bit, 16);
    check("ovf_srq", srq_cnt - s0, 0);
    o0 = orst_cnt;
    spi_txn(1, -1);
    check("novf_hdr", mi_w[0], hdr_exp(1, 0, 1));
    check("novf_orst_cnt", orst_cnt - o0, 0);

    // Saturation at BUF_DEPTH=4 with a 6-word acked transaction
    tick(); arm();
    s0 = srq_cnt;
    mo_w[0] = 16'hFFFF;
    for (int i = 1; i <= 6; i++) mo_w[i] = 16'hA000 + 16'(i);
    spi_txn(6, -1);
    check("sat_hdr", mi_w[0], hdr_exp(0, 0, 1));
    check("sat_d0", mi_w[1], 16'h5555);
    check("sat_d1", mi_w[2], 16'hAAAA);
    check("sat_d2", mi_w[3], 16'h4444);
    check("sat_d3", mi_w[4], 16'hC000);
    check("sat_d4", mi_w[5], 16'h0000);
    check("sat_d5", mi_w[6], 16'h0000);
    check("sat_srq", srq_cnt - s0, 1);
    tick(); cpu_rst();
    rd_chk("sat_mem0", 16'hA001);
    rd_chk("sat_mem1", 16'hA002);
    rd_chk("sat_mem2", 16'hA003);
    rd_chk("sat_mem3", 16'hA004);
    rd_chk("sat_wrap", 16'hA001);

    // Third acked transaction aborted by reset: no srq, no write
    arm();
    s0 = srq_cnt;
    mo_w[0] = 16'hFFFF; mo_w[1] = 16'hB001; mo_w[2] = 16'hB002;
    spi_txn(2, 20);
    check("seq3_hdr", mi_w[0], hdr_exp(0, 0, 2));
    check("abort_srq", srq_cnt - s0, 0);
    check("abort_miso", spi_miso, 1);
    check("abort_orst", hb_orst, 0);
    check("abort_dout", host_dout, 0);
    tick();
    rd_chk("abort_mem0", 16'hA001);
    rd_chk("abort_mem1", 16'hA002);

    // Fourth transaction after reset: counter back to zero
    arm();
    s0 = srq_cnt;
    mo_w[0] = 16'hFFFF; mo_w[1] = 16'h7777;
    spi_txn(1, -1);
    check("seq4_hdr", mi_w[0], hdr_exp(0, 0, 0));
    check("seq4_d0", mi_w[1], 16'hA001);
    check("seq4_srq", srq_cnt - s0, 1);
    tick(); cpu_rst();
    rd_chk("seq4_mem0", 16'h7777);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
